pc_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the MIPS core.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch/execute bus between the PC sequencer, instruction memory and datapath.
// The master modport is the sequencer side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, err,
    input  imem_ack, imem_rdata, exec_done, branch_taken, branch_offset,
           jump, jump_target, jr, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, err,
    output imem_ack, imem_rdata, exec_done, branch_taken, branch_offset,
           jump, jump_target, jr, jr_addr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner for the MIPS core: fetches over req/ack, holds the
// instruction during execution, selects the next PC, and stops on errors.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Priority jr > jump > branch > sequential; all sums wrap modulo 2^32.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        if (bus.jr) begin
            next_pc = bus.jr_addr;
        end else if (bus.jump) begin
            next_pc = {pc_plus4[31:28], bus.jump_target, 2'b00};
        end else if (bus.branch_taken) begin
            next_pc = pc_plus4 + {bus.branch_offset[29:0], 2'b00};
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        wait_d          = wait_q;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.err         = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            EXEC: begin
                bus.instr_valid = 1'b1;
                if (bus.exec_done) begin
                    // A misaligned target leaves the PC pointing at the faulting instruction.
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = ERROR;
                    end else begin
                        pc_d    = next_pc;
                        wait_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            ERROR: begin
                bus.err = 1'b1;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc_out    = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.instr     = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: next-PC vector table, hand-written latency, timeout
// and async-reset sequences, then random traffic against a behavioural model.
module tb_pc_sequencer;

    localparam int unsigned MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic        jr;
        logic [31:0] jra;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    typedef enum {M_IDLE, M_FETCH, M_EXEC, M_ERR} mphase_t;
    mphase_t     m_ph;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int unsigned m_misses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.jr            = 1'b0;
        bus.jr_addr       = '0;
    endtask

    // Leaves the bench at the negedge where reset is released (DUT in IDLE).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fetch_to_exec(input logic [31:0] addr, input logic [31:0] data);
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, addr);
        chk("fetch_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("exec_valid", 32'(bus.instr_valid), 32'd1);
        chk("exec_instr", bus.instr, data);
        chk("exec_req", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic finish_exec(input logic br, input logic [31:0] off, input logic jmp,
                               input logic [25:0] tgt, input logic j_r, input logic [31:0] jra);
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.jump          = jmp;
        bus.jump_target   = tgt;
        bus.jr            = j_r;
        bus.jr_addr       = jra;
        bus.exec_done     = 1'b1;
        @(negedge clk);
        clear_inputs();
    endtask

    function automatic void model_reset();
        m_ph     = M_IDLE;
        m_pc     = RESET_PC;
        m_instr  = '0;
        m_misses = 0;
    endfunction

    // One rising edge of the architectural behaviour, from the current inputs.
    function automatic void model_edge();
        logic [31:0] tgt;
        case (m_ph)
            M_IDLE: begin
                m_ph = M_FETCH;
                m_misses = 0;
            end
            M_FETCH: begin
                if (bus.imem_ack) begin
                    m_instr = bus.imem_rdata;
                    m_ph = M_EXEC;
                end else begin
                    m_misses++;
                    if (m_misses == MAX_WAIT) m_ph = M_ERR;
                end
            end
            M_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.jr) tgt = bus.jr_addr;
                    else if (bus.jump) tgt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(bus.jump_target) * 32'd4);
                    else if (bus.branch_taken) tgt = m_pc + 32'd4 + bus.branch_offset * 32'd4;
                    else tgt = m_pc + 32'd4;
                    if (tgt % 4 != 0) begin
                        m_ph = M_ERR;
                    end else begin
                        m_pc = tgt;
                        m_ph = M_FETCH;
                        m_misses = 0;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic cmp_model();
        chk("m_req", 32'(bus.imem_req), 32'(m_ph == M_FETCH));
        chk("m_valid", 32'(bus.instr_valid), 32'(m_ph == M_EXEC));
        chk("m_err", 32'(bus.err), 32'(m_ph == M_ERR));
        chk("m_pc", bus.pc_out, m_pc);
        chk("m_addr", bus.imem_addr, m_pc);
        chk("m_plus4", bus.pc_plus4, m_pc + 32'd4);
        chk("m_instr", bus.instr, m_instr);
    endtask

    initial begin
        int unsigned ack_rate;
        int unsigned done_rate;
        int unsigned req_cycles;
        logic [31:0] r;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        clear_inputs();

        vecs[0]  = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_00FC, 1'b0};
        vecs[1]  = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h0000040, 1'b0, 32'h0,         32'h0000_0100, 1'b0};
        vecs[2]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 26'h0000040, 1'b1, 32'h0000_2000, 32'h0000_2000, 1'b0};
        vecs[3]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_2002, 32'h0000_0010, 1'b1};
        vecs[4]  = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[5]  = '{32'h0800_0000, 1'b1, 32'h0000_0010, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0800_0044, 1'b0};
        vecs[6]  = '{32'hF000_0010, 1'b0, 32'h0,         1'b1, 26'h3FFFFFF, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[7]  = '{32'h0000_0020, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0024, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 26'h0000001, 1'b0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[9]  = '{32'h0000_0040, 1'b1, 32'h0000_7FFF, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0002_0040, 1'b0};
        vecs[10] = '{32'h0000_0200, 1'b1, 32'h0000_0004, 1'b0, 26'h0,       1'b1, 32'h0000_0001, 32'h0000_0200, 1'b1};

        // Reset values while held, then sequential run with single-cycle acks.
        #3;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", bus.pc_out, RESET_PC);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        do_reset();
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            fetch_to_exec(32'(i) * 32'd4, 32'hA5A5_0000 + 32'(i));
            finish_exec(1'b0, '0, 1'b0, '0, 1'b0, '0);
        end

        // Next-PC table: reach start_pc via jr, execute one instruction, check outcome.
        for (int v = 0; v < 11; v++) begin
            do_reset();
            @(negedge clk);
            fetch_to_exec(RESET_PC, 32'h0000_0008);
            finish_exec(1'b0, '0, 1'b0, '0, 1'b1, vecs[v].start_pc);
            fetch_to_exec(vecs[v].start_pc, 32'h1234_0000 + 32'(v));
            finish_exec(vecs[v].br, vecs[v].off, vecs[v].jmp, vecs[v].tgt, vecs[v].jr, vecs[v].jra);
            chk($sformatf("vec%0d_pc", v), bus.pc_out, vecs[v].exp_pc);
            chk($sformatf("vec%0d_req", v), 32'(bus.imem_req), 32'(!vecs[v].exp_err));
            chk($sformatf("vec%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
            @(negedge clk);
            chk($sformatf("vec%0d_hold", v), bus.pc_out, vecs[v].exp_pc);
        end

        // Timeout: no ack for MAX_WAIT cycles.
        do_reset();
        @(negedge clk);
        req_cycles = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.imem_req) req_cycles++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", req_cycles, MAX_WAIT);
        chk("timeout_err", 32'(bus.err), 32'd1);
        chk("timeout_pc", bus.pc_out, RESET_PC);

        // Ack arriving on the last permitted FETCH cycle.
        do_reset();
        @(negedge clk);
        for (int k = 1; k < int'(MAX_WAIT); k++) @(negedge clk);
        fetch_to_exec(RESET_PC, 32'h0BAD_F00D);
        chk("late_ack_err", 32'(bus.err), 32'd0);

        // Async reset mid-FETCH.
        do_reset();
        @(negedge clk);
        fetch_to_exec(RESET_PC, 32'h1);
        finish_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0040);
        #2 reset = 1'b0;
        #1;
        chk("arst_fetch_req", 32'(bus.imem_req), 32'd0);
        chk("arst_fetch_pc", bus.pc_out, RESET_PC);
        chk("arst_fetch_instr", bus.instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst_fetch_restart", bus.imem_addr, RESET_PC);

        // Async reset mid-EXEC.
        fetch_to_exec(RESET_PC, 32'h2);
        finish_exec(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0040);
        fetch_to_exec(32'h0000_0040, 32'hCAFE_BABE);
        #2 reset = 1'b0;
        #1;
        chk("arst_exec_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_exec_pc", bus.pc_out, RESET_PC);
        chk("arst_exec_instr", bus.instr, 32'd0);
        chk("arst_exec_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst_exec_restart_req", 32'(bus.imem_req), 32'd1);
        chk("arst_exec_restart", bus.imem_addr, RESET_PC);

        // Random traffic against the behavioural model.
        do_reset();
        model_reset();
        ack_rate  = 90;
        done_rate = 60;
        for (int c = 0; c < 4000; c++) begin
            cmp_model();
            if ($urandom_range(99) < ((m_ph == M_ERR) ? 25 : 1)) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                cmp_model();
                @(negedge clk);
                reset = 1'b1;
                case ($urandom_range(2))
                    0: ack_rate = 95;
                    1: ack_rate = 50;
                    default: ack_rate = 20;
                endcase
                done_rate = $urandom_range(90, 20);
            end
            bus.imem_ack      = ($urandom_range(99) < ack_rate);
            bus.imem_rdata    = $urandom;
            bus.exec_done     = ($urandom_range(99) < done_rate);
            bus.branch_taken  = ($urandom_range(3) == 0);
            r                 = $urandom;
            bus.branch_offset = {{16{r[15]}}, r[15:0]};
            bus.jump          = ($urandom_range(5) == 0);
            bus.jump_target   = 26'($urandom);
            bus.jr            = ($urandom_range(7) == 0);
            bus.jr_addr       = ($urandom_range(9) == 0) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFC);
            model_edge();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
